// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared run state type and default timing constants for the counter control stage
package count_ctrl_pkg;
  typedef enum logic {STOPPED, RUNNING} run_state_t;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_DEBOUNCE = 8;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes, debounces and rising-edge detects one raw push button
module btn_debounce
  import count_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic differ, settle;
  assign differ = sync[1] != level;
  assign settle = differ && cnt == CW'(DEBOUNCE - 1);
  // two-flop synchronizer, stability count, level flip once stable long enough, press on a new high level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      cnt <= (!differ || settle) ? '0 : cnt + CW'(1);
      level <= level ^ settle;
      press <= settle && !level;
    end
endmodule

// File: rtl/count_enable_gen.sv
// count_enable_gen: turns bouncy run/step buttons into the downstream counter's enable strobe
module count_enable_gen
  import count_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_run,
  input  logic btn_step,
  output logic enable,
  output logic running
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  run_state_t state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic enable_nxt, run_press, step_press, wrap;
  logic [1:0] lvl_unused;
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_run (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_run), .level(lvl_unused[0]), .press(run_press)
  );
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_step (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_step), .level(lvl_unused[1]), .press(step_press)
  );
  assign wrap = pre == PW'(CLK_DIV - 1);
  assign running = state == RUNNING;
  // run press toggles state and restarts the prescaler; a step only counts while stopped and run wins ties
  always_comb begin
    state_nxt = run_press ? (running ? STOPPED : RUNNING) : state;
    pre_nxt = (!running || run_press || wrap) ? '0 : pre + PW'(1);
    enable_nxt = running ? (!run_press && wrap) : (step_press && !run_press);
  end
  // state, prescaler and registered enable strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= STOPPED;
      pre <= '0;
      enable <= 1'b0;
    end else begin
      state <= state_nxt;
      pre <= pre_nxt;
      enable <= enable_nxt;
    end
endmodule

// File: tb/tb_count_enable_gen.sv
// tb_count_enable_gen: directed and random button stimulus against a behavioural model with a mod-10 counter downstream
module tb_count_enable_gen;
  localparam int CD = 4;
  localparam int DB = 8;
  logic clk = 1'b0, rst_n = 1'b0, btn_run = 1'b0, btn_step = 1'b0;
  logic enable, running;
  int checks = 0, failures = 0;
  int dcount = 0;

  count_enable_gen #(.CLK_DIV(CD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_step(btn_step),
    .enable(enable), .running(running)
  );

  always #5 clk = ~clk;

  // downstream mod-10 counter, deliberately not reset by rst_n
  always @(posedge clk) if (enable) dcount <= (dcount + 1) % 10;

  // model: a button level flips once the last DB two-cycle-delayed samples all disagree with it;
  // enable follows from press events and the number of cycles spent running
  logic m_run = 1'b0, m_en = 1'b0;
  int m_since = 0, m_cnt = 0;
  logic [1:0] m_lev = '0, m_press = '0, d1 = '0, d2 = '0, raw;
  logic [DB-1:0] win [2];
  initial begin
    win[0] = '0;
    win[1] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_run = 1'b0; m_en = 1'b0; m_lev = '0; m_press = '0; d1 = '0; d2 = '0;
        win[0] = '0; win[1] = '0;
      end else begin
        if (m_en) m_cnt = (m_cnt + 1) % 10;
        m_en = 1'b0;
        if (!m_run) begin
          if (m_press[0]) begin m_run = 1'b1; m_since = 0; end
          else m_en = m_press[1];
        end else if (m_press[0]) m_run = 1'b0;
        else begin
          m_since++;
          m_en = (m_since % CD) == 0;
        end
        raw = {btn_step, btn_run};
        for (int b = 0; b < 2; b++) begin
          win[b] = {win[b][DB-2:0], d2[b]};
          m_press[b] = 1'b0;
          if (win[b] == {DB{~m_lev[b]}}) begin
            m_lev[b] = ~m_lev[b];
            m_press[b] = m_lev[b];
          end
        end
        d2 = d1;
        d1 = raw;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (enable !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL reset: enable=%b running=%b, required 0 0", enable, running);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== 1'b0 || running !== 1'b0) begin
        failures++;
        $display("FAIL glitch cycle %0d: enable=%b running=%b, required 0 0", i, enable, running);
      end
      btn_run = (i < 5) || (i >= 8 && i < 13);
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 28; i++) begin
        @(negedge clk);
        checks++;
        if (enable !== m_en || running !== m_run || dcount != m_cnt) begin
          failures++;
          $display("FAIL step: enable=%b running=%b count=%0d, required %b %b %0d", enable, running, dcount, m_en, m_run, m_cnt);
        end
        if (enable) pulses++;
        btn_step = i < 12;
      end
    checks++;
    if (pulses != 3 || dcount != 3) begin
      failures++;
      $display("FAIL step totals: pulses=%0d count=%0d, required 3 3", pulses, dcount);
    end
  endtask

  task automatic test_run_press();
    int rise = 0, last = -1, pulses = 0;
    btn_run = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== m_en || running !== m_run || dcount != m_cnt) begin
        failures++;
        $display("FAIL run_press: enable=%b running=%b count=%0d, required %b %b %0d", enable, running, dcount, m_en, m_run, m_cnt);
      end
      if (running && rise == 0) rise = i;
      if (enable) begin
        if (last >= 0) begin
          checks++;
          if (i - last != CD) begin
            failures++;
            $display("FAIL run_period: gap=%0d, required %0d", i - last, CD);
          end
        end
        last = i;
        pulses++;
      end
      if (i == 20) btn_run = 1'b0;
    end
    checks++;
    if (rise != 11 || pulses != 14 || dcount != 7) begin
      failures++;
      $display("FAIL run_press timing: rise=%0d pulses=%0d count=%0d, required 11 14 7", rise, pulses, dcount);
    end
  endtask

  task automatic test_step_while_running();
    int pulses = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== m_en || running !== m_run || dcount != m_cnt) begin
        failures++;
        $display("FAIL step_running: enable=%b running=%b count=%0d, required %b %b %0d", enable, running, dcount, m_en, m_run, m_cnt);
      end
      if (enable) pulses++;
      btn_step = i < 12;
    end
    checks++;
    if (pulses != 8) begin
      failures++;
      $display("FAIL step_running pulses: got %0d, required 8", pulses);
    end
  endtask

  task automatic test_stop_restart();
    int stop_at = 0, rise = 0, first = 0;
    bit found = 0;
    for (int i = 0; i < 2 * CD && !found; i++) begin
      @(negedge clk);
      if (enable) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stop align: enable=0 for %0d cycles, required a pulse", 2 * CD);
    end
    btn_run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== m_en || running !== m_run || dcount != m_cnt) begin
        failures++;
        $display("FAIL stop: enable=%b running=%b count=%0d, required %b %b %0d", enable, running, dcount, m_en, m_run, m_cnt);
      end
      if (!running && stop_at == 0) stop_at = i;
      if (stop_at != 0) begin
        checks++;
        if (enable !== 1'b0) begin
          failures++;
          $display("FAIL stop quiet cycle %0d: enable=%b, required 0", i, enable);
        end
      end
      if (i == 14) btn_run = 1'b0;
    end
    btn_run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== m_en || running !== m_run || dcount != m_cnt) begin
        failures++;
        $display("FAIL restart: enable=%b running=%b count=%0d, required %b %b %0d", enable, running, dcount, m_en, m_run, m_cnt);
      end
      if (running && rise == 0) rise = i;
      if (enable && first == 0) first = i;
      if (i == 14) btn_run = 1'b0;
    end
    checks++;
    if (stop_at != 11 || rise != 11 || first != 15) begin
      failures++;
      $display("FAIL stop_restart timing: stop=%0d rise=%0d first=%0d, required 11 11 15", stop_at, rise, first);
    end
  endtask

  task automatic test_simultaneous();
    int rise = 0, first = 0;
    btn_run = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== m_en || running !== m_run || dcount != m_cnt) begin
        failures++;
        $display("FAIL simul stop: enable=%b running=%b count=%0d, required %b %b %0d", enable, running, dcount, m_en, m_run, m_cnt);
      end
      if (i == 14) btn_run = 1'b0;
    end
    btn_run = 1'b1;
    btn_step = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== m_en || running !== m_run || dcount != m_cnt) begin
        failures++;
        $display("FAIL simul: enable=%b running=%b count=%0d, required %b %b %0d", enable, running, dcount, m_en, m_run, m_cnt);
      end
      if (running && rise == 0) rise = i;
      if (enable && first == 0) first = i;
      if (i == 14) begin btn_run = 1'b0; btn_step = 1'b0; end
    end
    checks++;
    if (rise != 11 || first != 15) begin
      failures++;
      $display("FAIL simul timing: rise=%0d first=%0d, required 11 15", rise, first);
    end
  endtask

  task automatic test_reset_mid_run();
    int held;
    bit found = 0;
    for (int i = 0; i < 2 * CD && !found; i++) begin
      @(negedge clk);
      if (enable) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid align: enable=0 for %0d cycles, required a pulse", 2 * CD);
    end
    held = dcount;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (enable !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid async: enable=%b running=%b, required 0 0", enable, running);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== 1'b0 || running !== 1'b0 || dcount != held || m_cnt != held) begin
        failures++;
        $display("FAIL reset_mid hold: enable=%b running=%b count=%0d, required 0 0 %0d", enable, running, dcount, held);
      end
    end
  endtask

  task automatic test_random();
    int hr = 0, hs = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if (enable !== m_en || running !== m_run || dcount != m_cnt) begin
        failures++;
        $display("FAIL random cycle %0d: enable=%b running=%b count=%0d, required %b %b %0d", i, enable, running, dcount, m_en, m_run, m_cnt);
      end
      if (hr == 0) begin btn_run = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 24); end
      else hr--;
      if (hs == 0) begin btn_step = 1'($urandom_range(0, 1)); hs = $urandom_range(1, 24); end
      else hs--;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_step();
    test_run_press();
    test_step_while_running();
    test_stop_restart();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
